// File: rtl/wc_stream_driver.sv
// Host-side driver for the Winograd core: packs bytes into D words, tracks them through the
// core latency, and queues Z results. Optional in_last early flush under WC_DRV_FLUSH_EN.
module wc_stream_driver #(
  parameter int LANES      = 10,
  parameter int DW         = 8,
  parameter int ZW         = 4,
  parameter int CORE_LAT   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_valid,
`ifdef WC_DRV_FLUSH_EN
  input  logic                  in_last,
`endif
  output logic                  in_ready,
  output logic [LANES*DW-1:0]   d_out,
  input  logic [LANES*ZW-1:0]   z_in,
  output logic [LANES*ZW-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + CORE_LAT + 1) + 1;

  typedef enum logic {S_FILL, S_WAIT} state_t;

  state_t                state_q, state_n;
  logic [IW-1:0]         idx_q;
  logic [LANES*DW-1:0]   pack_q, pack_w;
  logic [CORE_LAT-1:0]   tag_q, tag_next;
  logic [LANES*ZW-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [PW:0]           cnt_q;
  logic [CW-1:0]         occ;
  logic                  accept, word_done, launch, credit, capture, pop, last_in;

`ifdef WC_DRV_FLUSH_EN
  assign last_in = in_last;
`else
  assign last_in = 1'b0;
`endif

  assign in_ready  = (state_q == S_FILL) && !rst;
  assign accept    = in_valid && in_ready;
  assign word_done = accept && ((idx_q == IW'(LANES-1)) || last_in);
  assign capture   = tag_q[CORE_LAT-1];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rptr_q] : '0;

  generate
    if (CORE_LAT == 1) begin : g_tag1
      assign tag_next = launch;
    end else begin : g_tagn
      assign tag_next = {tag_q[CORE_LAT-2:0], launch};
    end
  endgenerate

  // Credit uses pre-edge occupancy only; a same-cycle pop is deliberately ignored.
  always_comb begin
    occ = CW'(cnt_q);
    for (int i = 0; i < CORE_LAT; i++) occ = occ + CW'(tag_q[i]);
    credit = occ < CW'(FIFO_DEPTH);
  end

  // Upper lanes are already zero after each launch, so an early flush needs no masking.
  always_comb begin
    pack_w = pack_q;
    if (accept)
      for (int k = 0; k < LANES; k++)
        if (idx_q == IW'(k)) pack_w[k*DW +: DW] = in_data;
  end

  always_comb begin
    state_n = state_q;
    launch  = 1'b0;
    case (state_q)
      S_FILL: if (word_done) begin
        if (credit) launch = 1'b1;
        else        state_n = S_WAIT;
      end
      S_WAIT: if (credit) begin
        launch  = 1'b1;
        state_n = S_FILL;
      end
      default: state_n = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FILL;
    else     state_q <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      pack_q <= '0;
      d_out  <= '0;
      tag_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      tag_q <= tag_next;
      if (launch) begin
        d_out  <= pack_w;
        pack_q <= '0;
        idx_q  <= '0;
      end else if (accept) begin
        pack_q <= pack_w;
        idx_q  <= word_done ? '0 : idx_q + IW'(1);
      end
      if (capture) wptr_q <= wptr_q + PW'(1);
      if (pop)     rptr_q <= rptr_q + PW'(1);
      case ({capture, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && capture) mem[wptr_q] <= z_in;
  end
endmodule

// File: tb/tb_wc_stream_driver.sv
// Directed bench for wc_stream_driver; the core is modelled as returning the low 40 bits of
// the launched D word (or a fixed constant in the first step).
module tb_wc_stream_driver;
  localparam int LANES = 10, DW = 8, ZW = 4, CORE_LAT = 4, FIFO_DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0, in_ready;
  logic [79:0] d_out;
  logic [39:0] z_in, out_data, zconst = 40'h123456789A;
  logic        zmode = 1'b0, out_valid, out_ready = 1'b1;
`ifdef WC_DRV_FLUSH_EN
  logic        in_last = 1'b0;
`endif

  int ncmp = 0, nfail = 0, cyc = 0, stalls = 0;
  logic [79:0] prev_d = '0;
  int          launch_cyc[$];
  logic [39:0] res_q[$];

  wc_stream_driver #(.LANES(LANES), .DW(DW), .ZW(ZW), .CORE_LAT(CORE_LAT),
                     .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef WC_DRV_FLUSH_EN
    .in_last(in_last),
`endif
    .in_ready(in_ready), .d_out(d_out), .z_in(z_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;
  assign z_in = zmode ? d_out[39:0] : zconst;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (d_out !== prev_d) begin
      launch_cyc.push_back(cyc);
      prev_d <= d_out;
    end
    if (out_valid && out_ready) res_q.push_back(out_data);
    if (!rst && dut.tag_q[CORE_LAT-1])
      chk("no_overflow_at_capture", 80'(dut.cnt_q < 3'(FIFO_DEPTH)), 80'd1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 80'd1, 80'd0);
    if (n > 0) stalls += n;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [79:0] pack_word(input logic [7:0] b);
    logic [79:0] w;
    for (int k = 0; k < 10; k++) w[k*8 +: 8] = b + 8'(k);
    return w;
  endfunction

  function automatic logic [39:0] low_res(input logic [7:0] b);
    logic [79:0] w;
    w = pack_word(b);
    return w[39:0];
  endfunction

  initial begin
    logic [79:0] w;
    // reset state
    tick(2);
    chk("rst_d_out", d_out, 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_out_data", 80'(out_data), 80'd0);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", 80'(in_ready), 80'd1);

    // first word, constant Z
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    chk("word1_d_out", d_out, 80'h0A090807060504030201);
    tick(3);
    chk("word1_no_early_valid", 80'(out_valid), 80'd0);
    tick(1);
    chk("word1_out_valid", 80'(out_valid), 80'd1);
    chk("word1_out_data", 80'(out_data), 80'h123456789A);
    tick(1);
    chk("word1_popped", 80'(out_valid), 80'd0);

    // 30 bytes back-to-back
    zmode = 1'b1;
    launch_cyc.delete(); res_q.delete(); stalls = 0;
    for (int i = 0; i < 30; i++) send_byte(8'(8'h20 + i));
    tick(10);
    chk("stream_stalls", 80'(stalls), 80'd0);
    chk("stream_launches", 80'(launch_cyc.size()), 80'd3);
    if (launch_cyc.size() == 3) begin
      chk("stream_gap1", 80'(launch_cyc[1] - launch_cyc[0]), 80'd10);
      chk("stream_gap2", 80'(launch_cyc[2] - launch_cyc[1]), 80'd10);
    end
    chk("stream_results", 80'(res_q.size()), 80'd3);
    for (int i = 0; i < 3 && i < res_q.size(); i++)
      chk("stream_res", 80'(res_q[i]), 80'(low_res(8'(8'h20 + 10*i))));

    // backpressure: park in WAIT
    out_ready = 1'b0;
    launch_cyc.delete(); res_q.delete();
    for (int i = 0; i < 50; i++) send_byte(8'(8'h40 + i));
    in_data = 8'h40 + 8'd50; in_valid = 1'b1;
    tick(20);
    chk("bp_launches", 80'(launch_cyc.size()), 80'd4);
    chk("bp_in_ready", 80'(in_ready), 80'd0);
    chk("bp_out_valid", 80'(out_valid), 80'd1);
    chk("bp_head", 80'(out_data), 80'(low_res(8'h40)));
    out_ready = 1'b1;
    tick(1);
    chk("bp_no_launch_on_pop", d_out, pack_word(8'h40 + 8'd30));
    chk("bp_still_wait", 80'(in_ready), 80'd0);
    tick(1);
    chk("bp_launch_after_pop", d_out, pack_word(8'h40 + 8'd40));
    chk("bp_back_to_fill", 80'(in_ready), 80'd1);
    for (int i = 50; i < 60; i++) send_byte(8'(8'h40 + i));
    tick(20);
    chk("bp_total_launches", 80'(launch_cyc.size()), 80'd6);
    chk("bp_results", 80'(res_q.size()), 80'd6);
    for (int i = 0; i < 6 && i < res_q.size(); i++)
      chk("bp_res", 80'(res_q[i]), 80'(low_res(8'(8'h40 + 10*i))));

    // reset mid-word
    for (int i = 0; i < 5; i++) send_byte(8'(8'h90 + i));
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("midrst_d_out", d_out, 80'd0);
    tick(1);
    launch_cyc.delete(); res_q.delete();
    for (int i = 0; i < 10; i++) send_byte(8'(8'h11 + i));
    chk("midrst_word", d_out, 80'h1A191817161514131211);
    tick(10);
    chk("midrst_results", 80'(res_q.size()), 80'd1);
    if (res_q.size() > 0) chk("midrst_res", 80'(res_q[0]), 80'h1514131211);

    // reset with two words outstanding
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send_byte(8'(8'hC0 + i));
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("flight_rst_valid", 80'(out_valid), 80'd0);
    out_ready = 1'b1;
    res_q.delete();
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("flight_rst_stays_empty", 80'(out_valid), 80'd0);
    end
    chk("flight_rst_results", 80'(res_q.size()), 80'd0);

`ifdef WC_DRV_FLUSH_EN
    // early flush on in_last
    launch_cyc.delete(); res_q.delete();
    send_byte(8'hAA);
    in_last = 1'b1;
    send_byte(8'hBB);
    in_last = 1'b0;
    chk("flush_d_out", d_out, 80'h0000000000000000BBAA);
    tick(10);
    chk("flush_results", 80'(res_q.size()), 80'd1);
    if (res_q.size() > 0) chk("flush_res", 80'(res_q[0]), 80'h000000BBAA);
`endif

    w = '0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
